// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment table for the seven_seg_mux display driver.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active low (0 = segment lit).
package seven_seg_pkg;

    // All segments dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Number of brightness steps; one slot is split into this many PWM slices.
    localparam int PWM_LEVELS = 16;

    // Active-low hex glyphs.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational nibble to active-low 7-segment decoder ({g,f,e,d,c,b,a}).
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure table lookup, no state.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Multiplexed common-anode hex display driver.
// Scans NUM_DIGITS digits, one slot of DIV = CLK_HZ/SCAN_HZ cycles per digit.
// Data is double buffered: a load fills the pending buffer and the display
// buffer is only refreshed on the last cycle of a frame, so a frame never
// mixes old and new digits. digit_en and brightness act live.
// Optional build macro: SEVEN_SEG_LZ_SUPPRESS_EN blanks leading zero digits.
//
// Interface handshake: load is a single-cycle strobe with no back-pressure;
// data and dp_in are sampled on every rising edge where load is 1, and the
// driver is always ready to accept it.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 8
)(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int SLICE = DIV / PWM_LEVELS;
    localparam int CW    = $clog2(DIV);
    localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Wide enough for (brightness+1)*SLICE, which never exceeds DIV.
    localparam int LW    = CW + 5;

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]             count;
    logic [IW-1:0]             idx;
    logic                      slot_end;
    logic                      frame_end;

    logic [4*NUM_DIGITS-1:0]   pend_data;
    logic [NUM_DIGITS-1:0]     pend_dp;
    logic [4*NUM_DIGITS-1:0]   disp_data;
    logic [NUM_DIGITS-1:0]     disp_dp;

    logic [NUM_DIGITS-1:0]     eligible;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_en;
    logic                      cur_elig;
    logic [6:0]                cur_seg;
    logic [LW-1:0]             on_limit;
    logic                      lit;
    logic                      show;

    assign slot_end  = (count == CNT_MAX);
    assign frame_end = slot_end && (idx == IDX_MAX);

    // Prescaler and digit index: count runs 0..DIV-1, index advances once per slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
            idx   <= '0;
        end else begin
            count <= slot_end ? '0 : count + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Pending/display buffers; a load on the frame_end cycle goes straight to display.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_data <= '0;
            pend_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else begin
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp_in;
            end
            if (frame_end) begin
                disp_data <= load ? data  : pend_data;
                disp_dp   <= load ? dp_in : pend_dp;
            end
        end
    end

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
    logic keep;

    // A digit survives if it or any higher digit is nonzero or has its dp set; digit 0 always survives.
    always_comb begin
        keep     = 1'b0;
        eligible = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            keep        = keep | (disp_data[4*i +: 4] != 4'h0) | disp_dp[i];
            eligible[i] = keep;
        end
        eligible[0] = 1'b1;
    end
`else
    // Without suppression every digit is shown, gated only by digit_en.
    always_comb begin
        eligible = '1;
    end
`endif

    // Select the nibble, dp and gating bits of the digit currently being scanned.
    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_en   = 1'b0;
        cur_elig = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib  = disp_data[4*i +: 4];
                cur_dp   = disp_dp[i];
                cur_en   = digit_en[i];
                cur_elig = eligible[i];
            end
        end
    end

    // PWM: lit for the first (brightness+1) slices of the slot.
    always_comb begin
        on_limit = (LW'(brightness) + LW'(1)) * LW'(SLICE);
        lit      = (LW'(count) < on_limit);
        show     = lit && cur_en && cur_elig;
    end

    seven_seg_decoder u_decoder (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Registered pin drive; at most one anode is pulled low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            anode   <= '1;
            cathode <= SEG_OFF;
            dp      <= 1'b1;
        end else if (show) begin
            anode   <= ~(NUM_DIGITS'(1) << idx);
            cathode <= cur_seg;
            dp      <= ~cur_dp;
        end else begin
            anode   <= '1;
            cathode <= SEG_OFF;
            dp      <= 1'b1;
        end
    end

endmodule
